mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder for the RV32I core.
- Sequences every instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Drives instruction/data memory request handshakes and all datapath strobes, and adds a memory timeout and a retired-instruction counter.
- Sits between the instruction register, ALU/branch compare and the memory bus adapter.

Parameters:
- ALUOP_W, 2: width of alu_op; encodings 00 add, 01 branch-compare, 10 R-type funct, 11 I-type funct, zero-extended if wider.
- CNT_W, 32: width of the instret counter.
- MEM_TIMEOUT, 256: cycles to wait for a memory ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- stall  in  1  freeze the sequencer
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete
- branch_taken  in  1  ALU compare result, valid in EXEC
- imem_req  out  1  fetch request, level
- ir_write  out  1  load the instruction register, pulse
- pc_write  out  1  update the PC, pulse
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- alu_op  out  ALUOP_W  ALU operation class
- alu_src_a  out  2  00 rs1, 01 old PC, 10 zero
- alu_src_b  out  2  00 rs2, 01 immediate
- dmem_read  out  1  load request, level
- dmem_write  out  1  store request, level
- mem_to_reg  out  2  00 ALU, 01 memory, 10 PC (link)
- reg_write  out  1  register file write, pulse
- retire  out  1  instruction completed, pulse
- bus_err  out  1  memory timeout, pulse
- illegal  out  1  illegal opcode trap (see Optional Feature)
- instret  out  CNT_W  retired-instruction count
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5

Behaviour:
- Registered elements: state, op_q, tmo_cnt, instret, illegal. All other outputs are combinational from state, op_q and the inputs.
- While rst=1, every output is 0. After reset: state=FETCH, instret=0, tmo_cnt=0, illegal=0.
- stall=1 has priority over everything:
  - state and all counters hold;
  - ir_write, pc_write, reg_write, retire and bus_err are forced to 0;
  - imem_req, dmem_read and dmem_write stay at their state values;
  - ready inputs are ignored.
- FETCH: imem_req=1. On imem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE: op_q <= opcode, then go to EXEC. An unknown opcode is handled as described under Optional Feature.
- EXEC, decoded from op_q:
  - R 0110011: alu_op=10, src_a=00, src_b=00, go to WB.
  - I-ALU 0010011: alu_op=11, src_b=01, go to WB.
  - Load 0000011 / Store 0100011: alu_op=00, src_b=01, go to MEM.
  - Branch 1100011: alu_op=01, src_b=00, pc_src=01, pc_write=branch_taken, go to FETCH and retire.
  - JAL 1101111 / JALR 1100111: pc_src=10, pc_write=1, go to WB.
  - LUI 0110111: alu_op=00, src_a=10, src_b=01, go to WB.
  - AUIPC 0010111: alu_op=00, src_a=01, src_b=01, go to WB.
- MEM:
  - Load: dmem_read=1 held until dmem_ready, then go to WB.
  - Store: dmem_write=1 held until dmem_ready, then go to FETCH and retire.
- WB: reg_write=1 for one cycle, then go to FETCH and retire.
  - mem_to_reg=01 for a load, 10 for JAL/JALR, 00 otherwise.
- Retire: retire=1 for one cycle on the transition into FETCH; instret increments and wraps from all-ones to 0.
- Timeout:
  - tmo_cnt counts non-stalled cycles in FETCH or MEM without ready and clears on every state change.
  - When MEM_TIMEOUT>0 and tmo_cnt reaches MEM_TIMEOUT-1 with no ready: bus_err=1 for one cycle, the request drops, state goes to FETCH, no retire.
  - If ready arrives in the same cycle as the timeout, ready wins.
- Reset mid-access: requests drop in the same cycle rst is sampled; no retire, no bus_err.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
  - Defined: an unknown opcode in DECODE goes to TRAP. illegal=1 is held, all other strobes are 0, and the block stays in TRAP until rst.
  - Undefined: an unknown opcode is treated as a NOP. DECODE goes to FETCH with retire=1. The TRAP state is unreachable and illegal is tied to 0.

Test Plan:
- R-type 0110011, imem_ready on the first FETCH cycle -> states 0,1,2,4,0; reg_write=1 in cycle 4, mem_to_reg=00; instret 0->1.
- Load, dmem_ready after 3 MEM cycles -> dmem_read high exactly 3 cycles, WB with mem_to_reg=01, 7 cycles total, retire once.
- Branch with branch_taken=1, then again with 0 -> pc_write=1 with pc_src=01 in EXEC only in the first case; both retire after 3 cycles, no reg_write.
- MEM_TIMEOUT=4, store with dmem_ready never asserted -> dmem_write high 4 cycles, then bus_err pulse, state=0, instret unchanged.
- stall=1 for 5 cycles in WB -> reg_write=0 while stalled, state holds at 4; on release reg_write pulses once and retire pulses once.
- opcode 0000000 -> with CTRL_ILLEGAL_TRAP_EN: state=5, illegal=1 until rst. Without it: 2-cycle NOP, retire=1, instret+1. Separately, instret preset to all-ones wraps to 0 on the next retire.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Drives the memory request handshakes and datapath strobes, and provides a
// memory-ready timeout and a retired-instruction counter.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state
// instead of retiring as a NOP.
module mc_control_unit #(
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               stall,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               branch_taken,
  output logic               imem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               retire,
  output logic               bus_err,
  output logic               illegal,
  output logic [CNT_W-1:0]   instret,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic TMO_EN = (MEM_TIMEOUT != 0);

  state_t           st_q, st_nxt;
  logic [6:0]       op_q;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] instret_q;

  logic       imem_req_c, ir_write_c, pc_write_c, dmem_read_c, dmem_write_c;
  logic       reg_write_c, retire_c, bus_err_c, waiting_c, known_op;
  logic [1:0] pc_src_c, alu_op_c, alu_src_a_c, alu_src_b_c, mem_to_reg_c;

  // Opcode recognised by the sequencer (evaluated on the live IR during DECODE)
  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known_op = 1'b1;
      default:                            known_op = 1'b0;
    endcase
  end

  // Next-state and raw (unmasked) strobe decode
  always_comb begin
    st_nxt       = st_q;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    alu_op_c     = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    dmem_read_c  = 1'b0;
    dmem_write_c = 1'b0;
    mem_to_reg_c = 2'b00;
    reg_write_c  = 1'b0;
    retire_c     = 1'b0;
    bus_err_c    = 1'b0;
    waiting_c    = 1'b0;
    case (st_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          st_nxt     = DECODE;
        end else begin
          waiting_c = 1'b1;
          if (TMO_EN && tmo_q == TMO_LAST) begin
            bus_err_c = 1'b1;
            st_nxt    = FETCH;
          end
        end
      end
      DECODE: begin
        if (known_op) begin
          st_nxt = EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          st_nxt = TRAP;
`else
          st_nxt   = FETCH;
          retire_c = 1'b1;
`endif
        end
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op_c = 2'b10;
            st_nxt   = WB;
          end
          OP_I: begin
            alu_op_c    = 2'b11;
            alu_src_b_c = 2'b01;
            st_nxt      = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_c = 2'b01;
            st_nxt      = MEM;
          end
          OP_BR: begin
            alu_op_c   = 2'b01;
            pc_src_c   = 2'b01;
            pc_write_c = branch_taken;
            retire_c   = 1'b1;
            st_nxt     = FETCH;
          end
          OP_JAL, OP_JALR: begin
            pc_src_c   = 2'b10;
            pc_write_c = 1'b1;
            st_nxt     = WB;
          end
          OP_LUI: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            st_nxt      = WB;
          end
          OP_AUIPC: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            st_nxt      = WB;
          end
          default: st_nxt = FETCH;
        endcase
      end
      MEM: begin
        if (op_q == OP_LOAD) dmem_read_c = 1'b1;
        else                 dmem_write_c = 1'b1;
        if (dmem_ready) begin
          if (op_q == OP_LOAD) begin
            st_nxt = WB;
          end else begin
            st_nxt   = FETCH;
            retire_c = 1'b1;
          end
        end else begin
          waiting_c = 1'b1;
          if (TMO_EN && tmo_q == TMO_LAST) begin
            bus_err_c = 1'b1;
            st_nxt    = FETCH;
          end
        end
      end
      WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        st_nxt      = FETCH;
        if (op_q == OP_LOAD)                       mem_to_reg_c = 2'b01;
        else if (op_q == OP_JAL || op_q == OP_JALR) mem_to_reg_c = 2'b10;
      end
      TRAP:    st_nxt = TRAP;
      default: st_nxt = FETCH;
    endcase
  end

  // Sequencer state, latched opcode, timeout and retire counters; all frozen by stall
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= FETCH;
      op_q      <= '0;
      tmo_q     <= '0;
      instret_q <= '0;
    end else if (!stall) begin
      st_q <= st_nxt;
      if (st_q == DECODE) op_q <= opcode;
      // A timeout returns FETCH to FETCH, so it must clear the counter explicitly
      if (st_nxt != st_q || bus_err_c) tmo_q <= '0;
      else if (waiting_c)              tmo_q <= tmo_q + TMO_W'(1);
      if (retire_c) instret_q <= instret_q + CNT_W'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                           illegal_q <= 1'b0;
    else if (!stall && st_nxt == TRAP) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q & ~rst;
`else
  assign illegal = 1'b0;
`endif

  // Levels are masked only by reset; pulses are also suppressed while stalled
  assign imem_req   = imem_req_c & ~rst;
  assign dmem_read  = dmem_read_c & ~rst;
  assign dmem_write = dmem_write_c & ~rst;
  assign ir_write   = ir_write_c & ~rst & ~stall;
  assign pc_write   = pc_write_c & ~rst & ~stall;
  assign reg_write  = reg_write_c & ~rst & ~stall;
  assign retire     = retire_c & ~rst & ~stall;
  assign bus_err    = bus_err_c & ~rst & ~stall;
  assign pc_src     = rst ? 2'b00 : pc_src_c;
  assign alu_op     = rst ? '0 : ALUOP_W'(alu_op_c);
  assign alu_src_a  = rst ? 2'b00 : alu_src_a_c;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
  assign mem_to_reg = rst ? 2'b00 : mem_to_reg_c;
  assign instret    = rst ? '0 : instret_q;
  assign state      = rst ? 3'd0 : st_q;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst, stall, imem_ready, dmem_ready, branch_taken;
  logic [6:0] opcode;
  logic       imem_req, ir_write, pc_write, dmem_read, dmem_write;
  logic       reg_write, retire, bus_err, illegal;
  logic [1:0] pc_src, alu_op, alu_src_a, alu_src_b, mem_to_reg;
  logic [2:0] instret, state;

  mc_control_unit #(.ALUOP_W(2), .CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .stall(stall),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retire(retire), .bus_err(bus_err), .illegal(illegal),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, ir_write, pc_write;
    logic [1:0] pc_src, alu_op, alu_src_a, alu_src_b;
    logic       dmem_read, dmem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write, retire, bus_err, illegal;
    logic [2:0] state, instret;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
  } sb_t;

  sb_t        sbq[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [2:0] exp_instret = '0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_t  it;
      obs_t act;
      it  = sbq.pop_front();
      act = '{imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b,
              dmem_read, dmem_write, mem_to_reg, reg_write, retire, bus_err, illegal,
              state, instret};
      n_checks++;
      if (act === it.e) n_pass++;
      else $display("FAIL %s: actual st=%0d inst=%0d bits=%b, required st=%0d inst=%0d bits=%b",
                    it.nm, act.state, act.instret, act[24:6],
                    it.e.state, it.e.instret, it.e[24:6]);
    end
  end

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
  endtask

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.state = st;
    e.instret = exp_instret;
    return e;
  endfunction

  task automatic step(input string nm, input obs_t e);
    sb_t it;
    it.nm = nm;
    it.e  = e;
    sbq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int unsigned waits);
    obs_t e;
    imem_ready = 1'b0;
    for (int unsigned i = 0; i < waits; i++) begin
      e = base(3'd0); e.imem_req = 1'b1;
      step("fetch_wait", e);
    end
    imem_ready = 1'b1;
    e = base(3'd0); e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("fetch", e);
    imem_ready = 1'b0;
  endtask

  task automatic do_decode(input logic [6:0] op, input bit nop);
    obs_t e;
    opcode = op;
    e = base(3'd1);
    e.retire = nop;
    step(nop ? "decode_nop" : "decode", e);
    if (nop) exp_instret++;
  endtask

  task automatic do_exec(input string nm, input logic [1:0] aop, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [1:0] psrc, input logic pcw,
                         input logic ret);
    obs_t e;
    e = base(3'd2);
    e.alu_op = aop; e.alu_src_a = sa; e.alu_src_b = sb;
    e.pc_src = psrc; e.pc_write = pcw; e.retire = ret;
    step(nm, e);
    if (ret) exp_instret++;
  endtask

  task automatic do_wb(input logic [1:0] m2r);
    obs_t e;
    e = base(3'd4); e.reg_write = 1'b1; e.retire = 1'b1; e.mem_to_reg = m2r;
    step("wb", e);
    exp_instret++;
  endtask

  task automatic mem_cycle(input string nm, input logic ld, input logic rdy, input logic err,
                           input logic ret);
    obs_t e;
    dmem_ready = rdy;
    e = base(3'd3);
    e.dmem_read = ld; e.dmem_write = ~ld; e.bus_err = err; e.retire = ret;
    step(nm, e);
    if (ret) exp_instret++;
    dmem_ready = 1'b0;
  endtask

  task automatic r_type();
    do_fetch(0); do_decode(OP_R, 0);
    do_exec("exec_r", 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    do_wb(2'b00);
  endtask

  initial begin
    obs_t e;
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    branch_taken = 1'b0; opcode = '0;
    @(posedge clk); #1;
    imem_ready = 1'b1;
    step("reset_outputs", '0);
    step("reset_outputs", '0);
    rst = 1'b0; imem_ready = 1'b0;
    #1;
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_instret", 32'(instret), 32'd0);
    check_eq("reset_illegal", 32'(illegal), 32'd0);

    r_type();

    do_fetch(1); do_decode(OP_I, 0);
    do_exec("exec_i", 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    do_wb(2'b00);

    do_fetch(0); do_decode(OP_LD, 0);
    do_exec("exec_ld", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    mem_cycle("ld_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    mem_cycle("ld_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    mem_cycle("ld_done", 1'b1, 1'b1, 1'b0, 1'b0);
    do_wb(2'b01);

    do_fetch(0); do_decode(OP_BR, 0);
    branch_taken = 1'b1;
    do_exec("br_taken", 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1);
    branch_taken = 1'b0;
    do_fetch(0); do_decode(OP_BR, 0);
    do_exec("br_not_taken", 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1);

    do_fetch(0); do_decode(OP_JAL, 0);
    do_exec("exec_jal", 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
    do_wb(2'b10);
    do_fetch(0); do_decode(OP_JALR, 0);
    do_exec("exec_jalr", 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
    do_wb(2'b10);

    do_fetch(0); do_decode(OP_LUI, 0);
    do_exec("exec_lui", 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    do_wb(2'b00);
    do_fetch(0); do_decode(OP_AUIPC, 0);
    do_exec("exec_auipc", 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    do_wb(2'b00);

    do_fetch(0); do_decode(OP_ST, 0);
    do_exec("exec_st", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    mem_cycle("st_done", 1'b0, 1'b1, 1'b0, 1'b1);

    do_fetch(0); do_decode(OP_ST, 0);
    do_exec("exec_st", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) mem_cycle("st_tmo_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    mem_cycle("st_timeout", 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tmo_state", 32'(state), 32'd0);
    check_eq("tmo_instret", 32'(instret), 32'(exp_instret));
    check_eq("tmo_refetch_req", 32'(imem_req), 32'd1);

    do_fetch(3); do_decode(OP_LD, 0);
    do_exec("exec_ld", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) mem_cycle("ld_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    mem_cycle("ld_ready_at_limit", 1'b1, 1'b1, 1'b0, 1'b0);
    do_wb(2'b01);

    for (int i = 0; i < 3; i++) begin
      e = base(3'd0); e.imem_req = 1'b1; step("fetch_tmo_wait", e);
    end
    e = base(3'd0); e.imem_req = 1'b1; e.bus_err = 1'b1; step("fetch_timeout", e);
    r_type();

    do_fetch(0); do_decode(OP_R, 0);
    do_exec("exec_r", 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step("wb_stalled", base(3'd4));
    stall = 1'b0;
    do_wb(2'b00);

    stall = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = base(3'd0); e.imem_req = 1'b1; step("fetch_stalled", e);
    end
    stall = 1'b0;
    do_fetch(0); do_decode(OP_LD, 0);
    do_exec("exec_ld", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) mem_cycle("mem_stalled", 1'b1, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    mem_cycle("ld_done", 1'b1, 1'b1, 1'b0, 1'b0);
    do_wb(2'b01);

    do_fetch(0); do_decode(OP_LD, 0);
    do_exec("exec_ld", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    mem_cycle("ld_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("reset_mid_access", '0);
    rst = 1'b0;
    exp_instret = '0;

    for (int i = 0; i < 8; i++) r_type();
    e = base(3'd0); e.imem_req = 1'b1;
    step("instret_wrapped", e);

    do_fetch(0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    do_decode(7'b0000000, 0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = base(3'd5); e.illegal = 1'b1; step("trap_hold", e);
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst = 1'b1;
    step("trap_reset", '0);
    rst = 1'b0;
    exp_instret = '0;
`else
    do_decode(7'b0000000, 1);
`endif
    r_type();

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
